// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the instruction-cache frame, tag and FSM types.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam int ICACHE_SETS  = 16;
   localparam int ICACHE_IDX_W = 4;

   typedef logic [25:0] icache_tag_t;

   typedef struct packed {
      logic        valid;
      icache_tag_t tag;
      word_t       data;
   } icache_frame_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage for the direct-mapped icache: combinational read, synchronous fill write,
// single-cycle flush of every valid bit, asynchronous reset of the valid bits only.
module icache_frame_array
   import cpu_types_pkg::*;
#(
   parameter int SETS  = ICACHE_SETS,
   parameter int IDX_W = ICACHE_IDX_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [IDX_W-1:0] ridx,
   output icache_frame_t    rframe,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  icache_tag_t      wtag,
   input  word_t            wdata,
   input  logic             flush
);

   logic [SETS-1:0] valid;
   icache_tag_t     tags [SETS];
   word_t           data [SETS];

   // Flush beats a same-cycle fill so the filled frame stays invalid.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid <= '0;
      end else if (flush) begin
         valid <= '0;
      end else if (we) begin
         valid[widx] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (we) begin
         tags[widx] <= wtag;
         data[widx] <= wdata;
      end
   end

   always_comb begin
      rframe       = '0;
      rframe.valid = valid[ridx];
      rframe.tag   = tags[ridx];
      rframe.data  = data[ridx];
   end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: zero-latency hits, single outstanding fill via
// an IDLE/FETCH FSM, full flush, and hit/miss counters.
module icache_direct
   import cpu_types_pkg::*;
#(
   parameter int SETS  = ICACHE_SETS,
   parameter int IDX_W = ICACHE_IDX_W
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          imemREN,
   input  logic [31:0]   imemaddr,
   output logic          ihit,
   output logic [31:0]   imemload,
   output logic          iREN,
   output logic [31:0]   iaddr,
   input  logic          iwait,
   input  logic [31:0]   iload,
   input  logic          flush,
   output logic [31:0]   hit_count,
   output logic [31:0]   miss_count,
   output icache_state_t dbg_state
);

   // Memory handshake: iREN stays high from the cycle after the miss until the cycle where
   // iwait is low; iload is captured in that cycle. iREN/iaddr come only from registers.

   icache_state_t    state;
   word_t            miss_addr;
   logic [IDX_W-1:0] req_idx;
   logic [IDX_W-1:0] fill_idx;
   icache_tag_t      req_tag;
   icache_tag_t      fill_tag;
   icache_frame_t    rframe;
   logic             lookup;
   logic             hit;
   logic             miss;
   logic             fill_done;

   assign req_idx  = imemaddr[IDX_W+1:2];
   assign req_tag  = icache_tag_t'(imemaddr >> (IDX_W + 2));
   assign fill_idx = miss_addr[IDX_W+1:2];
   assign fill_tag = icache_tag_t'(miss_addr >> (IDX_W + 2));

   // A flush cycle neither reports a hit nor starts a miss.
   assign lookup    = (state == IDLE) && imemREN && !flush;
   assign hit       = lookup && rframe.valid && (rframe.tag == req_tag);
   assign miss      = lookup && !hit;
   assign fill_done = (state == FETCH) && !iwait;

   assign ihit      = hit;
   assign imemload  = hit ? rframe.data : '0;
   assign dbg_state = state;

   icache_frame_array #(
      .SETS  (SETS),
      .IDX_W (IDX_W)
   ) u_frames (
      .CLK    (CLK),
      .RST    (RST),
      .ridx   (req_idx),
      .rframe (rframe),
      .we     (fill_done),
      .widx   (fill_idx),
      .wtag   (fill_tag),
      .wdata  (iload),
      .flush  (flush)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         miss_addr <= '0;
         iREN      <= 1'b0;
         iaddr     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss) begin
                  state     <= FETCH;
                  miss_addr <= imemaddr & ~32'd3;
                  iREN      <= 1'b1;
                  iaddr     <= imemaddr & ~32'd3;
               end
            end
            FETCH: begin
               // The fill always runs to completion, even after a redirect.
               if (!iwait) begin
                  state <= IDLE;
                  iREN  <= 1'b0;
                  iaddr <= '0;
               end
            end
            default: begin
               state <= IDLE;
               iREN  <= 1'b0;
               iaddr <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit) begin
            hit_count <= hit_count + 32'd1;
         end
         if (miss) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
// Directed and randomized bench for icache_direct against a frame-level reference model.
module tb_icache_direct;
   import cpu_types_pkg::*;

   logic          CLK;
   logic          RST;
   logic          imemREN;
   logic [31:0]   imemaddr;
   logic          ihit;
   logic [31:0]   imemload;
   logic          iREN;
   logic [31:0]   iaddr;
   logic          iwait;
   logic [31:0]   iload;
   logic          flush;
   logic [31:0]   hit_count;
   logic [31:0]   miss_count;
   icache_state_t dbg_state;

   icache_direct dut (
      .CLK        (CLK),
      .RST        (RST),
      .imemREN    (imemREN),
      .imemaddr   (imemaddr),
      .ihit       (ihit),
      .imemload   (imemload),
      .iREN       (iREN),
      .iaddr      (iaddr),
      .iwait      (iwait),
      .iload      (iload),
      .flush      (flush),
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // reference model: 16 frames indexed by word address mod 16
   logic        m_valid [16];
   logic [25:0] m_tag   [16];
   logic [31:0] m_data  [16];
   int unsigned m_hits;
   int unsigned m_misses;
   logic [31:0] exp_q[$];

   int n_tests;
   int n_fail;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic int m_idx(input logic [31:0] a);
      return int'((a >> 2) % 16);
   endfunction

   function automatic logic [25:0] m_tagof(input logic [31:0] a);
      return 26'(a >> 6);
   endfunction

   function automatic bit m_would_hit(input logic [31:0] a);
      return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic model_flush();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0; flush = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      model_reset();
   endtask

   task automatic chk_counters(input string name);
      chk({name, "_hits"}, hit_count, m_hits);
      chk({name, "_misses"}, miss_count, m_misses);
   endtask

   // Drives the FETCH cycles of an already-detected miss for address a. imemaddr shows bus_a
   // (a redirect when it differs from a); flush is raised in the fill cycle when flush_last.
   task automatic finish_fill(input logic [31:0] a, input int waits, input logic [31:0] d,
                              input logic [31:0] bus_a, input bit flush_last);
      for (int w = 0; w <= waits; w++) begin
         imemaddr = bus_a;
         iwait    = (w < waits);
         iload    = (w < waits) ? (32'hBAD0_0000 | 32'(w)) : d;
         flush    = flush_last && (w == waits);
         #2;
         chk("fetch_iren", {31'd0, iREN}, 32'd1);
         chk("fetch_iaddr", iaddr, a & ~32'd3);
         chk("fetch_ihit", {31'd0, ihit}, 32'd0);
         chk("fetch_imemload", imemload, 32'd0);
         chk("fetch_state", 32'(dbg_state), 32'(FETCH));
         @(posedge CLK);
         #1;
      end
      flush = 1'b0;
      iwait = 1'b1;
      iload = '0;
      if (flush_last) begin
         model_flush();
      end else begin
         m_valid[m_idx(a)] = 1'b1;
         m_tag[m_idx(a)]   = m_tagof(a);
         m_data[m_idx(a)]  = d;
      end
   endtask

   // Full fetch as the datapath sees it: hold the request until the model predicts a hit.
   task automatic do_fetch(input logic [31:0] a, input int waits, input logic [31:0] d);
      imemREN  = 1'b1;
      imemaddr = a;
      iwait    = 1'b1;
      flush    = 1'b0;
      #2;
      if (!m_would_hit(a)) begin
         chk("miss_ihit", {31'd0, ihit}, 32'd0);
         chk("miss_iren_idle", {31'd0, iREN}, 32'd0);
         chk("miss_iaddr_idle", iaddr, 32'd0);
         m_misses++;
         @(posedge CLK);
         #1;
         chk("miss_count", miss_count, m_misses);
         finish_fill(a, waits, d, a, 1'b0);
         imemaddr = a;
         #2;
      end
      if (m_would_hit(a)) begin
         exp_q.push_back(m_data[m_idx(a)]);
         chk("hit_ihit", {31'd0, ihit}, 32'd1);
         chk("hit_imemload", imemload, exp_q.pop_front());
         chk("hit_iren", {31'd0, iREN}, 32'd0);
         m_hits++;
      end else begin
         chk("post_fill_hit_expected", {31'd0, ihit}, 32'd1);
      end
      @(posedge CLK);
      #1;
      chk_counters("fetch");
   endtask

   task automatic idle_flush(input logic [31:0] a);
      imemREN  = 1'b1;
      imemaddr = a;
      flush    = 1'b1;
      #2;
      chk("flush_ihit", {31'd0, ihit}, 32'd0);
      chk("flush_imemload", imemload, 32'd0);
      @(posedge CLK);
      #1;
      flush = 1'b0;
      model_flush();
      chk("flush_no_miss_iren", {31'd0, iREN}, 32'd0);
      chk_counters("flush");
   endtask

   task automatic redirect(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] da, input logic [31:0] db);
      imemREN  = 1'b1;
      imemaddr = a;
      iwait    = 1'b1;
      flush    = 1'b0;
      #2;
      chk("redir_miss", {31'd0, ihit}, 32'd0);
      m_misses++;
      @(posedge CLK);
      #1;
      finish_fill(a, 2, da, b, 1'b0);
      do_fetch(b, 1, db);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      RST = 1'b1;
      imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0; flush = 1'b0;
      model_reset();
      #3;
      chk("reset_ihit", {31'd0, ihit}, 32'd0);
      chk("reset_imemload", imemload, 32'd0);
      chk("reset_iren", {31'd0, iREN}, 32'd0);
      chk("reset_iaddr", iaddr, 32'd0);
      chk_counters("reset");
      apply_reset();

      // cold miss
      do_fetch(32'h0000_0040, 3, 32'h8C22_0004);
      chk("cold_hits", hit_count, 32'd1);
      chk("cold_misses", miss_count, 32'd1);

      // conflict on index 1
      do_fetch(32'h0000_0004, 0, 32'h1111_0004);
      do_fetch(32'h0000_0044, 2, 32'h2222_0044);
      do_fetch(32'h0000_0004, 1, 32'h3333_0004);

      // redirects during FETCH
      redirect(32'h0000_0100, 32'h0000_0200, 32'hAAAA_0100, 32'hBBBB_0200);
      redirect(32'h0000_0104, 32'h0000_0208, 32'hCCCC_0104, 32'hDDDD_0208);
      do_fetch(32'h0000_0104, 0, 32'hFFFF_FFFF);

      // flush collides with the fill cycle
      imemREN = 1'b1; imemaddr = 32'h0000_0300; iwait = 1'b1;
      #2;
      chk("fcol_miss", {31'd0, ihit}, 32'd0);
      m_misses++;
      @(posedge CLK);
      #1;
      finish_fill(32'h0000_0300, 1, 32'h0300_0300, 32'h0000_0300, 1'b1);
      chk("fcol_hits_unchanged", hit_count, m_hits);
      do_fetch(32'h0000_0300, 0, 32'h0301_0301);
      do_fetch(32'h0000_0104, 0, 32'h0104_0104);
      idle_flush(32'h0000_0104);
      do_fetch(32'h0000_0104, 0, 32'h0105_0105);

      // async reset mid-fill
      do_fetch(32'h0000_0040, 0, 32'h4040_4040);
      imemREN = 1'b1; imemaddr = 32'h0000_0084; iwait = 1'b1;
      #2;
      chk("arst_miss", {31'd0, ihit}, 32'd0);
      m_misses++;
      @(posedge CLK);
      #1;
      chk("arst_fetch_iren", {31'd0, iREN}, 32'd1);
      #1;
      RST = 1'b1;
      #1;
      chk("arst_iren_drop", {31'd0, iREN}, 32'd0);
      chk("arst_iaddr", iaddr, 32'd0);
      chk("arst_state", 32'(dbg_state), 32'(IDLE));
      @(posedge CLK);
      #1;
      RST = 1'b0;
      imemREN = 1'b0;
      model_reset();
      chk("arst_hits_zero", hit_count, 32'd0);
      chk("arst_misses_zero", miss_count, 32'd0);
      do_fetch(32'h0000_0040, 0, 32'h4141_4141);
      chk("arst_refetch_misses", miss_count, 32'd1);

      // hit streak
      apply_reset();
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < 8; k++) begin
            do_fetch(32'(k * 4), 1, 32'hC0DE_0000 | 32'(k * 4));
         end
      end
      chk("streak_misses", miss_count, 32'd8);
      chk("streak_hits", hit_count, 32'd16);

      // randomized fetches over a few aliasing tags
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) begin
            idle_flush(a);
         end else if ($urandom_range(0, 9) == 0) begin
            imemREN = 1'b0;
            imemaddr = a;
            #2;
            chk("rand_idle_ihit", {31'd0, ihit}, 32'd0);
            chk("rand_idle_load", imemload, 32'd0);
            @(posedge CLK);
            #1;
            chk_counters("rand_idle");
         end else begin
            do_fetch(a, $urandom_range(0, 3), $urandom);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port and the memory controller's instruction port. Serves one-word blocks in 16 frames: a hit returns the instruction combinationally in the request cycle, and a miss runs a single outstanding fill through a two-state FSM. Includes hit and miss counters and a full invalidate, used by the halt/flush path.

## Interface
Parameters:
- SETS, 16, number of frames; power of two.
- IDX_W, 4, log2(SETS).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  reset, asynchronous, active-high.
- imemREN  in  1  fetch request from the datapath.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  instruction valid this cycle.
- imemload  out  32  instruction word; 0 when ihit=0.
- iREN  out  1  read request to the memory controller.
- iaddr  out  32  fill address, word-aligned.
- iwait  in  1  memory busy; iload is valid in the cycle where iREN=1 and iwait=0.
- iload  in  32  fill data.
- flush  in  1  invalidate all frames.
- hit_count  out  32  hits since reset.
- miss_count  out  32  misses since reset.

## Operation
- Address split: tag = imemaddr[31:IDX_W+2] (26 bits at default), index = imemaddr[IDX_W+1:2].
- Each frame holds valid, tag and data. At reset all valid bits = 0; data and tag contents do not matter.
- Hit condition: state IDLE, imemREN=1, valid[index]=1 and tag match.
  - ihit=1 and imemload=data[index] in the same cycle, combinationally.
  - hit_count increments by 1.
- FSM, state IDLE:
  - On imemREN=1 with no hit, latch imemaddr & ~3 into miss_addr.
  - Increment miss_count and go to FETCH.
- FSM, state FETCH:
  - iREN=1 and iaddr=miss_addr.
  - While iwait=1, stay in FETCH.
  - When iwait=0, write the frame at index(miss_addr): valid=1, tag=tag(miss_addr), data=iload. Then return to IDLE.
  - ihit stays 0 for the whole time in FETCH, including the fill cycle.
- The fill always completes; a memory read is never aborted.
  - If imemREN drops or imemaddr changes during FETCH (branch redirect), the fill for miss_addr still completes and is written.
  - If imemaddr then maps elsewhere, the next IDLE cycle misses again.
- flush=1 clears every valid bit at the clock edge.
  - If a fill completes in the same cycle, flush wins and that frame stays invalid.
  - In a flush cycle in IDLE, no hit is reported (ihit=0) and no miss is started.
- In IDLE: iREN=0 and iaddr=0.
- Counters are 32-bit, wrap modulo 2^32, and are cleared only by RST.

## Timing
- Reset values:
  - state = IDLE; all valid bits = 0.
  - ihit=0, imemload=0, iREN=0, iaddr=0, hit_count=0, miss_count=0.
- RST asserted mid-FETCH: the FSM returns to IDLE immediately and iREN drops asynchronously. The fill is not written.
- Hit latency: 0 cycles (combinational).
- Miss penalty:
  - cycle 0 is the miss detect;
  - iREN is asserted from cycle 1 through the cycle where iwait=0 (cycle 1+N, N = wait cycles);
  - the hit occurs in cycle 2+N.
- Back-to-back misses cost one IDLE cycle each between fills.
- Only one fill is outstanding at a time; the block never issues a new request during FETCH.
- iREN/iaddr are driven from state and miss_addr only, never from imemaddr.

## Structure
- The following go in cpu_types_pkg, next to word_t:
  - ICACHE_SETS and ICACHE_IDX_W;
  - icache_tag_t (26-bit logic vector);
  - icache_frame_t (packed struct: valid, tag, data word_t);
  - icache_state_t enum (IDLE, FETCH).
- One sub-module: icache_frame_array. It holds the SETS × icache_frame_t storage with:
  - a combinational read port;
  - a synchronous write port;
  - a one-cycle flush clear;
  - asynchronous reset of the valid bits.
- FSM, address split and counters stay in the top module.

## Test plan
- Cold miss: after RST, fetch 0x00000040 with iwait=1 for 3 cycles and iload=0x8C220004.
  - Required: iREN=1 and iaddr=0x40 for 4 cycles; ihit=1 with imemload=0x8C220004 on cycle 5; miss_count=1, hit_count=1.
- Conflict: fill 0x00000004, then fetch 0x00000044 (same index 1, different tag).
  - Required: a miss refills; fetching 0x04 afterwards misses again; miss_count=3.
- Redirect during FETCH: miss at 0x100, change imemaddr to 0x200 while iwait=1.
  - Required: iaddr stays 0x100 and the frame for 0x100 is written; the following cycle misses at 0x200.
- Flush collision: assert flush in the same cycle as the fill completes (iwait=0).
  - Required: the next fetch of the same address misses; hit_count is unchanged.
- Async reset mid-fill: assert RST during FETCH between clock edges.
  - Required: iREN=0 immediately; after release, the previously hit address 0x40 misses and counters read 0.
- Hit streak: loop 8 sequential addresses 0x0–0x1C twice, with 1 wait state per fill.
  - Required: miss_count=8, hit_count=16, and ihit is contiguous through the second pass.
